// File: rtl/dualrail_pkg.sv
// Shared types for the dual-rail token driver: FSM states, rail encodings
// and the helper that classifies a {rail1, rail0} pair.
package dualrail_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SET_WAIT,
        WAIT_ACK,
        REL_WAIT,
        WAIT_NULL,
        DONE
    } state_t;

    // Rail pairs are packed as {rail1, rail0}
    localparam logic [1:0] NEUTRAL = 2'b00;
    localparam logic [1:0] ZERO    = 2'b01;
    localparam logic [1:0] ONE     = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        RK_NEUTRAL,
        RK_ZERO,
        RK_ONE,
        RK_ILLEGAL
    } rail_kind_t;

    function automatic rail_kind_t classify_rails(input logic [1:0] pair);
        rail_kind_t kind;
        case (pair)
            NEUTRAL: kind = RK_NEUTRAL;
            ZERO:    kind = RK_ZERO;
            ONE:     kind = RK_ONE;
            default: kind = RK_ILLEGAL;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/dualrail_sync2.sv
// Two-flop synchronizer for an asynchronous dual-rail pair.
module dualrail_sync2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_pair,
    output logic [1:0] o_pair
);

    for (genvar gi = 0; gi < 2; gi++) begin : g_rail
        logic r_meta;
        logic r_sync;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_meta <= 1'b0;
                r_sync <= 1'b0;
            end else begin
                r_meta <= i_pair[gi];
                r_sync <= r_meta;
            end
        end

        assign o_pair[gi] = r_sync;
    end

endmodule

// File: rtl/dualrail_token_driver.sv
// Four-phase dual-rail initiator: sends a word LSB-first as tokens on bit0/bit1
// and gathers the responder's acknowledging rail into a result word.
import dualrail_pkg::*;

module dualrail_token_driver #(
    parameter int WIDTH   = 8,
    parameter int SETTLE  = 1,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             bit0,
    output logic             bit1,
    input  logic             parity0,
    input  logic             parity1,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             err
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_res;
    logic [IW-1:0]    r_idx;
    logic [SW-1:0]    r_scnt;
    logic [TW-1:0]    r_tcnt;
    logic             r_bit0;
    logic             r_bit1;
    logic             r_in_ready;
    logic             r_res_valid;
    logic             r_err;

    logic [1:0]  w_psync;
    rail_kind_t  w_kind;
    logic        w_ack;
    logic        w_null;
    logic        w_settled;
    logic        w_tlimit;
    logic        w_timeout;
    logic        w_fault;
    logic        w_last;
    logic [TW-1:0] w_tcnt_inc;

    dualrail_sync2 u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_pair ({parity1, parity0}),
        .o_pair (w_psync)
    );

    assign w_kind    = classify_rails(w_psync);
    assign w_ack     = (w_kind == RK_ZERO) || (w_kind == RK_ONE);
    assign w_null    = (w_kind == RK_NEUTRAL);
    assign w_settled = (r_scnt == SW'(SETTLE - 1));
    assign w_last    = (r_idx == IW'(WIDTH - 1));

    // An ack seen on the limit cycle wins: the timeout only fires without progress.
    assign w_tlimit  = (TIMEOUT > 0) && (r_tcnt == TW'(TIMEOUT - 1));
    assign w_timeout = w_tlimit &&
                       (((r_state == WAIT_ACK) && !w_ack) ||
                        ((r_state == WAIT_NULL) && !w_null));
    assign w_fault   = (w_kind == RK_ILLEGAL) || w_timeout ||
                       ((r_state == SET_WAIT) && !w_null);
    assign w_tcnt_inc = (r_tcnt == TW'(TIMEOUT)) ? r_tcnt : r_tcnt + TW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_res       <= '0;
            r_idx       <= '0;
            r_scnt      <= '0;
            r_tcnt      <= '0;
            r_bit0      <= 1'b0;
            r_bit1      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_in_ready <= 1'b0;
            if (w_fault) begin
                r_err       <= 1'b1;
                r_bit0      <= 1'b0;
                r_bit1      <= 1'b0;
                r_res_valid <= 1'b0;
                r_res       <= '0;
                r_state     <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (in_valid && r_in_ready) begin
                            r_shift <= in_data;
                            r_res   <= '0;
                            r_idx   <= '0;
                            r_scnt  <= '0;
                            r_state <= SET_WAIT;
                        end else begin
                            r_in_ready <= !r_err && w_null;
                        end
                    end
                    SET_WAIT: begin
                        if (w_settled) begin
                            r_bit1  <= r_shift[0];
                            r_bit0  <= !r_shift[0];
                            r_tcnt  <= '0;
                            r_state <= WAIT_ACK;
                        end else begin
                            r_scnt <= r_scnt + SW'(1);
                        end
                    end
                    WAIT_ACK: begin
                        if (w_ack) begin
                            r_res[r_idx] <= (w_kind == RK_ONE);
                            r_scnt       <= '0;
                            r_state      <= REL_WAIT;
                        end else begin
                            r_tcnt <= w_tcnt_inc;
                        end
                    end
                    REL_WAIT: begin
                        if (w_settled) begin
                            r_bit0  <= 1'b0;
                            r_bit1  <= 1'b0;
                            r_tcnt  <= '0;
                            r_state <= WAIT_NULL;
                        end else begin
                            r_scnt <= r_scnt + SW'(1);
                        end
                    end
                    WAIT_NULL: begin
                        if (w_null) begin
                            if (w_last) begin
                                r_res_valid <= 1'b1;
                                r_state     <= DONE;
                            end else begin
                                r_idx   <= r_idx + IW'(1);
                                r_shift <= r_shift >> 1;
                                r_scnt  <= '0;
                                r_state <= SET_WAIT;
                            end
                        end else begin
                            r_tcnt <= w_tcnt_inc;
                        end
                    end
                    DONE: begin
                        if (res_ready) begin
                            r_res_valid <= 1'b0;
                            r_in_ready  <= w_null;
                            r_state     <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign bit0      = r_bit0;
    assign bit1      = r_bit1;
    assign res_valid = r_res_valid;
    assign res_data  = r_res;
    assign err       = r_err;

endmodule
